// File: rtl/uart_rx_axis.sv
// 8N1 UART receiver (LSB first) with rxd synchronizer, start-glitch rejection,
// framing/overrun pulses and a one-entry valid/ready holding register.
module uart_rx_axis #(
    parameter int CLKS_PER_BIT = 868,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       io_uart_rxd,
    output logic [7:0] m_data,
    output logic       m_valid,
    input  logic       m_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);
    localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_HALF = BAUD_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t             state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic               rxs;
    logic [BAUD_W-1:0]  baud_q;
    logic [2:0]         bit_q;
    logic [7:0]         shift_q;
    logic               half_tick, bit_tick;
    logic               byte_done, stop_bad;

    // Synchronizer resets to all ones so a reset never looks like a start edge.
    // NOTE: every clocked process uses non-blocking assignments so all flops
    // update together from the values present before the edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) sync_q <= '1;
        else         sync_q <= {sync_q[SYNC_STAGES-2:0], io_uart_rxd};
    end

    assign rxs       = sync_q[SYNC_STAGES-1];
    assign half_tick = (baud_q == BAUD_HALF);
    assign bit_tick  = (baud_q == BAUD_LAST);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // NOTE: every combinational output gets a default before the case so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (!rxs)     state_d = S_START;
            S_START: if (half_tick) state_d = rxs ? S_IDLE : S_DATA;
            S_DATA:  if (bit_tick && bit_q == 3'd7) state_d = S_STOP;
            S_STOP:  if (bit_tick)  state_d = rxs ? S_IDLE : S_BREAK;
            S_BREAK: if (rxs)      state_d = S_IDLE;
            default:               state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q != S_IDLE);
        byte_done = 1'b0;
        stop_bad  = 1'b0;
        if (state_q == S_STOP && bit_tick) begin
            byte_done = rxs;
            stop_bad  = !rxs;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            unique case (state_q)
                S_START: baud_q <= half_tick ? '0 : baud_q + 1'b1;
                S_DATA: begin
                    if (bit_tick) begin
                        baud_q         <= '0;
                        bit_q          <= bit_q + 1'b1;
                        shift_q[bit_q] <= rxs;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                S_STOP: baud_q <= bit_tick ? '0 : baud_q + 1'b1;
                default: begin
                    baud_q <= '0;
                    bit_q  <= '0;
                end
            endcase
        end
    end

    // A completing byte may replace the held one only if it leaves this cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_data    <= '0;
            m_valid   <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= stop_bad;
            overrun   <= byte_done && m_valid && !m_ready;
            if (byte_done && (!m_valid || m_ready)) begin
                m_data  <= shift_q;
                m_valid <= 1'b1;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_axis.sv
// Directed bench for uart_rx_axis: a driver serialises frames and queues the
// expected bytes; a monitor pops and compares on every handshake.
`timescale 1ns/1ps
module tb_uart_rx_axis;
    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       resetn;
    logic       io_uart_rxd;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    always #5 clk = ~clk;

    uart_rx_axis #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .io_uart_rxd(io_uart_rxd),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    typedef struct {
        logic [7:0] data;
        int         cyc;   // expected handshake cycle, -1 when untimed
    } exp_t;

    exp_t sb[$];
    int   total  = 0;
    int   bad    = 0;
    int   cyc    = 0;
    int   fe_cnt = 0;
    int   ov_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Monitor: flag pulse counting, hold stability and scoreboard compare.
    initial begin
        logic       held;
        logic [7:0] held_data;
        exp_t       e;
        held = 1'b0;
        held_data = '0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                held = 1'b0;
            end else begin
                if (frame_err) fe_cnt++;
                if (overrun)   ov_cnt++;
                if (frame_err || overrun)
                    check("flags_exclusive", {31'b0, frame_err & overrun}, 0);
                if (held && m_valid) check("data_stable", {24'b0, m_data}, {24'b0, held_data});
                if (m_valid && m_ready) begin
                    if (sb.size() == 0) begin
                        check("unexpected_valid", {31'b0, m_valid}, 0);
                    end else begin
                        e = sb.pop_front();
                        check("rx_data", {24'b0, m_data}, {24'b0, e.data});
                        if (e.cyc >= 0) check("valid_latency", cyc, e.cyc);
                    end
                end
                held      = m_valid && !m_ready;
                held_data = m_data;
            end
        end
    end

    // Drive the line for n cycles; always returns 1 time unit after a rising edge.
    task automatic drive_bits(input logic v, input int n);
        io_uart_rxd = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Stop-bit midpoint is 9.5 bit periods after the start edge; m_valid
    // follows it by SYNC_STAGES + 1 = 3 cycles.
    task automatic send_byte(input logic [7:0] b, input logic stop_val,
                             input logic expect_out, input logic timed);
        exp_t e;
        if (expect_out) begin
            e.data = b;
            e.cyc  = timed ? cyc + 9 * CPB + CPB / 2 + 3 : -1;
            sb.push_back(e);
        end
        drive_bits(1'b0, CPB);
        for (int i = 0; i < 8; i++) drive_bits(b[i], CPB);
        drive_bits(stop_val, CPB);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_m_valid"},   {31'b0, m_valid},   0);
        check({tag, "_m_data"},    {24'b0, m_data},    0);
        check({tag, "_frame_err"}, {31'b0, frame_err}, 0);
        check({tag, "_overrun"},   {31'b0, overrun},   0);
        check({tag, "_busy"},      {31'b0, busy},      0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn      = 1'b0;
        io_uart_rxd = 1'b1;
        m_ready     = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        resetn = 1'b1;
        drive_bits(1'b1, 10);

        // Single byte with exact completion latency.
        send_byte(8'hA5, 1'b1, 1'b1, 1'b1);
        check("valid_one_cycle", {31'b0, m_valid}, 0);
        check("a5_no_frame_err", fe_cnt, 0);
        check("a5_no_overrun",   ov_cnt, 0);

        // Back-to-back frames, no idle gap.
        send_byte(8'h00, 1'b1, 1'b1, 1'b1);
        send_byte(8'hFF, 1'b1, 1'b1, 1'b1);
        send_byte(8'h55, 1'b1, 1'b1, 1'b1);
        drive_bits(1'b1, 4);
        check("b2b_drained", sb.size(), 0);
        check("b2b_no_flags", fe_cnt + ov_cnt, 0);

        // Start glitch: 5 low cycles.
        drive_bits(1'b0, 5);
        check("glitch_busy", {31'b0, busy}, 1);
        drive_bits(1'b1, 30);
        check("glitch_idle", {31'b0, busy}, 0);
        check("glitch_no_flags", fe_cnt + ov_cnt, 0);
        send_byte(8'h3C, 1'b1, 1'b1, 1'b1);

        // Stop bit low, then held low (break).
        send_byte(8'h81, 1'b0, 1'b0, 1'b0);
        drive_bits(1'b0, 20);
        check("break_busy", {31'b0, busy}, 1);
        check("frame_err_once", fe_cnt, 1);
        drive_bits(1'b1, 10);
        check("break_released", {31'b0, busy}, 0);
        send_byte(8'h42, 1'b1, 1'b1, 1'b1);
        check("frame_err_still_once", fe_cnt, 1);

        // Overrun with consumer stalled.
        m_ready = 1'b0;
        send_byte(8'h11, 1'b1, 1'b1, 1'b0);
        send_byte(8'h22, 1'b1, 1'b0, 1'b0);
        drive_bits(1'b1, 4);
        check("overrun_once",   ov_cnt, 1);
        check("overrun_valid",  {31'b0, m_valid}, 1);
        check("overrun_kept",   {24'b0, m_data}, 32'h11);
        m_ready = 1'b1;
        drive_bits(1'b1, 4);
        check("overrun_drained", {31'b0, m_valid}, 0);
        check("overrun_sb_empty", sb.size(), 0);

        // Reset mid-DATA of 0xC3 (bits LSB first: 1,1,0,...).
        drive_bits(1'b0, CPB);
        drive_bits(1'b1, CPB);
        drive_bits(1'b1, 8);
        resetn = 1'b0;
        #2;
        check_outputs_zero("midreset");
        io_uart_rxd = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("inreset");
        resetn = 1'b1;
        drive_bits(1'b1, 20);
        send_byte(8'h7E, 1'b1, 1'b1, 1'b1);
        drive_bits(1'b1, 10);
        check("final_sb_empty", sb.size(), 0);
        check("final_frame_err", fe_cnt, 1);
        check("final_overrun",   ov_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
